dsp_chain_2_fp16_sop2_operand_loader: RTL



---
 rtl/dsp_chain_2_fp16_sop2_operand_loader.sv | 102 ++++++++++
 1 files changed

// File: rtl/dsp_chain_2_fp16_sop2_operand_loader.sv
// Operand loader: packs 32 x 32-bit stream words into one 1024-bit frame for the 8-lane fp16 SOP array.
// Optional build macro LOADER_ZERO_PAD_EN: an early in_last zero-pads and emits the frame instead of discarding it.
module dsp_chain_2_fp16_sop2_operand_loader #(
   parameter int DATA_W = 32,
   parameter int WORDS  = 32,
   parameter int CNT_W  = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATA_W-1:0]         in_data,
   input  logic                      in_last,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W*WORDS-1:0]   out_data,
   output logic [CNT_W-1:0]          frame_cnt,
   output logic                      frame_err
);

   localparam int                FRAME_W  = DATA_W * WORDS;
   localparam int                IDX_W    = $clog2(WORDS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

   logic [IDX_W-1:0]   r_cnt;
   logic [FRAME_W-1:0] r_fill;
   logic [FRAME_W-1:0] r_out_data;
   logic               r_out_valid;
   logic [CNT_W-1:0]   r_frame_cnt;
   logic               r_frame_err;

   logic               w_last_idx;
   logic               w_early_last;
   logic               w_completing;
   logic               w_discard;
   logic               w_accept;
   logic               w_handoff;
   logic [FRAME_W-1:0] w_merged;

   // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
   always_comb begin
      w_last_idx   = (r_cnt == LAST_IDX);
      w_early_last = in_last && !w_last_idx;
`ifdef LOADER_ZERO_PAD_EN
      w_completing = w_last_idx || in_last;
`else
      w_completing = w_last_idx;
`endif
      w_discard    = w_early_last && !w_completing;
      // Only a completing word needs the hold register free; partial words always flow.
      in_ready     = !reset && (!r_out_valid || out_ready || !w_completing);
      w_accept     = in_valid && in_ready;
      w_handoff    = r_out_valid && out_ready;
      w_merged     = r_fill;
      w_merged[r_cnt*DATA_W +: DATA_W] = in_data;
   end

   // NOTE: state uses non-blocking assignments so all registers update together on the edge.
   // Words above cnt are already zero because the fill register is cleared on every completion/discard.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt      <= '0;
         r_fill     <= '0;
         r_out_data <= '0;
      end else if (w_accept) begin
         if (w_completing) begin
            r_out_data <= w_merged;
            r_fill     <= '0;
            r_cnt      <= '0;
         end else if (w_discard) begin
            r_fill     <= '0;
            r_cnt      <= '0;
         end else begin
            r_fill     <= w_merged;
            r_cnt      <= r_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_frame_cnt <= '0;
         r_frame_err <= 1'b0;
      end else begin
         if (w_accept && w_completing)
            r_out_valid <= 1'b1;
         else if (w_handoff)
            r_out_valid <= 1'b0;
         if (w_handoff)
            r_frame_cnt <= r_frame_cnt + 1'b1;
         if (w_accept && w_early_last)
            r_frame_err <= 1'b1;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign frame_cnt = r_frame_cnt;
   assign frame_err = r_frame_err;

endmodule
